// File: rtl/ps2_kb_pkg.sv
// ps2_kb_pkg: shared status bit positions and receiver state encoding
package ps2_kb_pkg;
   localparam int ST_NE   = 0;
   localparam int ST_FULL = 1;
   localparam int ST_OVR  = 2;
   localparam int ST_PERR = 3;
   localparam int ST_FERR = 4;
   localparam int ST_INH  = 5;
   localparam int ST_IEN  = 7;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;
endpackage

// File: rtl/ps2_kb_controller_rx.sv
// ps2_rx_frame: synchronises the PS/2 pins and deserialises one device-to-host frame
// per start bit, pulsing byte_valid_o on a good frame or perr_o/ferr_o on a bad one.
module ps2_rx_frame
   import ps2_kb_pkg::*;
#(
   parameter int SAMPLE_DELAY   = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       kb_clk_i,
   input  logic       kb_data_i,
   input  logic       inh_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       perr_o,
   output logic       ferr_o,
   output logic       idle_o,
   output logic       clk_hi_o
);
   localparam int DW = $clog2(SAMPLE_DELAY);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [1:0]    clk_s_q, dat_s_q;
   logic          clk_prev_q, pend_q, par_q, valid_q, perr_q, ferr_q;
   logic [DW-1:0] dly_q;
   logic [TW-1:0] tmo_q;
   logic [2:0]    bit_q;
   logic [7:0]    sr_q;
   rx_state_e     state_q;
   logic          fall, smp, tmo_hit, d, par_ok;
   assign fall    = clk_prev_q & ~clk_s_q[1] & ~inh_i;
   assign smp     = pend_q & (dly_q == '0);
   assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES);
   assign d       = dat_s_q[1];
   assign par_ok  = ^{sr_q, par_q};
   // The fall is seen one cycle after the synced edge, hence the -2 preload.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         clk_s_q    <= 2'b11;
         dat_s_q    <= 2'b11;
         clk_prev_q <= 1'b1;
         pend_q     <= 1'b0;
         dly_q      <= '0;
         tmo_q      <= '0;
         state_q    <= IDLE;
         bit_q      <= '0;
         sr_q       <= '0;
         par_q      <= 1'b0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         clk_s_q    <= {clk_s_q[0], kb_clk_i};
         dat_s_q    <= {dat_s_q[0], kb_data_i};
         clk_prev_q <= clk_s_q[1];
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         pend_q     <= fall | (pend_q & ~smp);
         dly_q      <= fall ? DW'(SAMPLE_DELAY - 2) : (pend_q & ~smp) ? dly_q - 1'b1 : dly_q;
         tmo_q      <= fall ? '0 : tmo_hit ? tmo_q : tmo_q + 1'b1;
         if (state_q != IDLE && tmo_hit) begin
            state_q <= IDLE;
            ferr_q  <= 1'b1;
         end else if (smp) begin
            case (state_q)
               IDLE: begin
                  state_q <= d ? IDLE : DATA;
                  bit_q   <= '0;
               end
               DATA: begin
                  sr_q    <= {d, sr_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  state_q <= (bit_q == 3'd7) ? PARITY : DATA;
               end
               PARITY: begin
                  par_q   <= d;
                  state_q <= STOP;
               end
               STOP: begin
                  state_q <= IDLE;
                  valid_q <= d & par_ok;
                  perr_q  <= d & ~par_ok;
                  ferr_q  <= ~d;
               end
            endcase
         end
      end
   end
   assign byte_o       = sr_q;
   assign byte_valid_o = valid_q;
   assign perr_o       = perr_q;
   assign ferr_o       = ferr_q;
   assign idle_o       = state_q == IDLE;
   assign clk_hi_o     = clk_s_q[1];
endmodule

// File: rtl/ps2_kb_controller.sv
// ps2_kb_controller: buffered PS/2 keyboard port for the Z180 with a scan-code FIFO,
// sticky error flags, level interrupt and host clock inhibit while the FIFO is full.
module ps2_kb_controller
   import ps2_kb_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int SAMPLE_DELAY   = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       KB_CLK_IN,
   input  logic       KB_DATA_IN,
   output logic       KB_CLK_OE,
   input  logic       SEL,
   input  logic       A0,
   input  logic       RD_N,
   input  logic       WR_N,
   input  logic [7:0] DIN,
   output logic [7:0] DOUT,
   output logic       DOE,
   output logic       IRQ_N
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0]   cnt_q;
   logic          ien_q, ovr_q, perr_q, ferr_q, inh_q, irq_n_q, rd_seen_q, wr_q;
   logic [7:0]    rx_byte, status;
   logic          rx_valid, rx_perr, rx_ferr, rx_idle, rx_clk_hi;
   logic          rd_act, wr_act, wr_first, empty, full, push, pop;
   logic [2:0]    clr;
   ps2_rx_frame #(.SAMPLE_DELAY(SAMPLE_DELAY), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk_i        (CLK),
      .rst_n_i      (RST),
      .kb_clk_i     (KB_CLK_IN),
      .kb_data_i    (KB_DATA_IN),
      .inh_i        (inh_q),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_valid),
      .perr_o       (rx_perr),
      .ferr_o       (rx_ferr),
      .idle_o       (rx_idle),
      .clk_hi_o     (rx_clk_hi)
   );
   assign rd_act   = SEL & ~RD_N;
   assign wr_act   = SEL & ~WR_N & A0;
   assign wr_first = wr_act & ~wr_q;
   assign empty    = cnt_q == '0;
   assign full     = cnt_q == (AW+1)'(FIFO_DEPTH);
   assign push     = rx_valid & ~full;
   assign pop      = rd_seen_q & ~rd_act & ~empty;
   assign clr      = wr_first ? DIN[4:2] : 3'b000;
   always_comb begin
      status          = '0;
      status[ST_NE]   = ~empty;
      status[ST_FULL] = full;
      status[ST_OVR]  = ovr_q;
      status[ST_PERR] = perr_q;
      status[ST_FERR] = ferr_q;
      status[ST_INH]  = inh_q;
      status[ST_IEN]  = ien_q;
   end
   always_ff @(posedge CLK) begin
      if (push) mem_q[wp_q] <= rx_byte;
   end
   // Flag sets are OR'd after the clear mask so a coincident set wins.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         wp_q      <= '0;
         rp_q      <= '0;
         cnt_q     <= '0;
         ien_q     <= 1'b0;
         ovr_q     <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         inh_q     <= 1'b0;
         irq_n_q   <= 1'b1;
         rd_seen_q <= 1'b0;
         wr_q      <= 1'b0;
      end else begin
         wp_q      <= wp_q + AW'(push);
         rp_q      <= rp_q + AW'(pop);
         cnt_q     <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
         rd_seen_q <= rd_act & (rd_seen_q | ~A0);
         wr_q      <= wr_act;
         ien_q     <= wr_first ? DIN[7] : ien_q;
         ovr_q     <= (rx_valid & full) | (ovr_q & ~clr[0]);
         perr_q    <= rx_perr | (perr_q & ~clr[1]);
         ferr_q    <= rx_ferr | (ferr_q & ~clr[2]);
         inh_q     <= full & (inh_q | (rx_idle & rx_clk_hi));
         irq_n_q   <= ~(ien_q & (~empty | ovr_q | perr_q | ferr_q));
      end
   end
   assign DOE       = rd_act;
   assign DOUT      = ~rd_act ? 8'h00 : A0 ? status : empty ? 8'h00 : mem_q[rp_q];
   assign KB_CLK_OE = inh_q;
   assign IRQ_N     = irq_n_q;
endmodule

// File: tb/tb_ps2_kb_controller.sv
// tb_ps2_kb_controller: directed PS/2 frames and CPU port accesses, with received
// scan codes checked against a queue of expected bytes.
module tb_ps2_kb_controller;
   localparam int HALF    = 20;
   localparam int TIMEOUT = 4096;
   logic       CLK = 1'b0, RST = 1'b0, KB_CLK_IN = 1'b1, KB_DATA_IN = 1'b1;
   logic       SEL = 1'b0, A0 = 1'b0, RD_N = 1'b1, WR_N = 1'b1;
   logic [7:0] DIN = 8'h00;
   logic [7:0] DOUT;
   logic       KB_CLK_OE, DOE, IRQ_N;
   int         vectors = 0, errs = 0;
   logic [7:0] exp_q [$];
   logic [7:0] fill [8] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43};

   ps2_kb_controller dut (
      .CLK        (CLK),
      .RST        (RST),
      .KB_CLK_IN  (KB_CLK_IN),
      .KB_DATA_IN (KB_DATA_IN),
      .KB_CLK_OE  (KB_CLK_OE),
      .SEL        (SEL),
      .A0         (A0),
      .RD_N       (RD_N),
      .WR_N       (WR_N),
      .DIN        (DIN),
      .DOUT       (DOUT),
      .DOE        (DOE),
      .IRQ_N      (IRQ_N)
   );

   always #5 CLK = ~CLK;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic bit_out(input logic b);
      @(negedge CLK) KB_DATA_IN = b;
      repeat (HALF) @(negedge CLK);
      KB_CLK_IN = 1'b0;
      repeat (HALF) @(negedge CLK);
      KB_CLK_IN = 1'b1;
   endtask

   task automatic frame(input logic [7:0] b, input logic par_bad = 1'b0, input int n = 11);
      logic [10:0] f;
      f = {1'b1, ~^b ^ par_bad, b, 1'b0};
      for (int i = 0; i < n; i++) bit_out(f[i]);
      @(negedge CLK) KB_DATA_IN = 1'b1;
      repeat (HALF) @(negedge CLK);
   endtask

   task automatic good(input logic [7:0] b);
      frame(b);
      exp_q.push_back(b);
   endtask

   task automatic rd(input logic a, output logic [7:0] v);
      @(negedge CLK) begin SEL = 1'b1; A0 = a; RD_N = 1'b0; end
      @(negedge CLK) v = DOUT;
      SEL = 1'b0; RD_N = 1'b1; A0 = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic rd_data(input string tag);
      logic [7:0] v, e;
      rd(1'b0, v);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      chk(tag, v, e);
   endtask

   task automatic st(input string tag, input logic [7:0] e);
      logic [7:0] v;
      rd(1'b1, v);
      chk(tag, v, e);
   endtask

   task automatic wr(input logic [7:0] v);
      @(negedge CLK) begin SEL = 1'b1; A0 = 1'b1; WR_N = 1'b0; DIN = v; end
      @(negedge CLK) begin SEL = 1'b0; A0 = 1'b0; WR_N = 1'b1; end
      @(negedge CLK);
   endtask

   initial begin
      logic [7:0] v, e;
      repeat (4) @(negedge CLK);
      chk("rst_oe", {7'd0, KB_CLK_OE}, 8'h00);
      chk("rst_irq", {7'd0, IRQ_N}, 8'h01);
      chk("rst_doe", {7'd0, DOE}, 8'h00);
      chk("rst_dout", DOUT, 8'h00);
      RST = 1'b1;
      @(negedge CLK);
      st("rst_status", 8'h00);
      rd_data("empty_read");
      // key with interrupt enabled
      wr(8'h80);
      chk("irq_idle", {7'd0, IRQ_N}, 8'h01);
      good(8'h1C);
      st("ne_ien", 8'h81);
      chk("irq_on", {7'd0, IRQ_N}, 8'h00);
      rd_data("key_1c");
      st("ne_clr", 8'h80);
      chk("irq_off", {7'd0, IRQ_N}, 8'h01);
      // bad parity
      wr(8'h00);
      frame(8'h5A, 1'b1);
      st("perr", 8'h08);
      rd_data("perr_empty");
      wr(8'h08);
      st("perr_clr", 8'h00);
      // timeout after data bit 3
      frame(8'h33, 1'b0, 5);
      repeat (TIMEOUT + 200) @(negedge CLK);
      st("ferr", 8'h10);
      good(8'hF0);
      st("ferr_ne", 8'h11);
      rd_data("key_f0");
      wr(8'h10);
      st("ferr_clr", 8'h00);
      // fill the FIFO, then one extra frame under inhibit
      for (int i = 0; i < 8; i++) good(fill[i]);
      st("full", 8'h23);
      chk("inh_on", {7'd0, KB_CLK_OE}, 8'h01);
      frame(8'h77);
      st("full_ignored", 8'h23);
      rd_data("full_pop");
      chk("inh_off", {7'd0, KB_CLK_OE}, 8'h00);
      for (int i = 0; i < 7; i++) rd_data("drain");
      st("drained", 8'h00);
      // push and pop in the same cycle at count 3
      good(8'hA1);
      good(8'hB2);
      good(8'hC3);
      frame(8'hD4, 1'b0, 10);
      @(negedge CLK) begin SEL = 1'b1; A0 = 1'b0; RD_N = 1'b0; end
      @(negedge CLK) KB_CLK_IN = 1'b0;
      repeat (10) @(posedge CLK);
      @(negedge CLK) v = DOUT;
      SEL = 1'b0; RD_N = 1'b1;
      e = exp_q.pop_front();
      chk("same_head", v, e);
      exp_q.push_back(8'hD4);
      for (int i = 0; i < 3; i++) begin
         chk("same_cnt", 8'(dut.cnt_q), 8'd3);
         @(negedge CLK);
      end
      repeat (HALF) @(negedge CLK);
      KB_CLK_IN = 1'b1;
      repeat (HALF) @(negedge CLK);
      for (int i = 0; i < 3; i++) rd_data("same_order");
      st("same_done", 8'h00);
      // reset during data bit 5 with a code pending and IEN set
      wr(8'h80);
      good(8'h11);
      chk("irq_pre", {7'd0, IRQ_N}, 8'h00);
      frame(8'h29, 1'b0, 6);
      @(negedge CLK) KB_DATA_IN = 1'b1;
      repeat (HALF) @(negedge CLK);
      KB_CLK_IN = 1'b0;
      repeat (5) @(negedge CLK);
      RST = 1'b0;
      repeat (5) @(negedge CLK);
      chk("mid_rst_irq", {7'd0, IRQ_N}, 8'h01);
      chk("mid_rst_oe", {7'd0, KB_CLK_OE}, 8'h00);
      KB_CLK_IN = 1'b1;
      repeat (5) @(negedge CLK);
      RST = 1'b1;
      exp_q.delete();
      repeat (5) @(negedge CLK);
      st("mid_rst_status", 8'h00);
      chk("mid_rst_irq2", {7'd0, IRQ_N}, 8'h01);
      good(8'h29);
      st("post_rst_ne", 8'h01);
      rd_data("key_29");
      st("final", 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
